// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the frame-RAM Wishbone arbiter.
// Holds the FSM state encoding and the round-robin/urgent pick function.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1,
        StAbort
    } arb_state_e;

    localparam int unsigned M0_IDX     = 0;
    localparam int unsigned M1_IDX     = 1;
    localparam logic [1:0]  GRANT_NONE = 2'b00;

    // last: 0 = M0 served last, 1 = M1 served last. Urgent M1 beats fairness on a tie.
    function automatic logic [1:0] rr_pick(logic [1:0] req, logic last, logic urgent);
        logic [1:0] pick;
        pick = GRANT_NONE;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = (urgent || !last) ? 2'b10 : 2'b01;
            default: pick = GRANT_NONE;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/wb_ram_arbiter_if.sv
// One Wishbone link (controls, address, data, ACK/ERR) with master/slave views.
// The arbiter sees requesters through the slave view and the RAM through the master view.
interface wb_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              stb;
    logic              cyc;
    logic              lock;
    logic              we;
    logic [3:0]        sel;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] rdat;
    logic              ack;
    logic              err;

    modport master (
        output stb, cyc, lock, we, sel, adr, wdat,
        input  ack, err, rdat
    );

    modport slave (
        input  stb, cyc, lock, we, sel, adr, wdat,
        output ack, err, rdat
    );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Stall counter for the current grant: counts STB-without-ACK cycles and
// flags expiry on the stalled cycle that brings the count to TIMEOUT-1.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic nRST,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int unsigned     CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = inc && (cnt_q == LAST);

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-requester Wishbone arbiter for frame RAM: video_in writer (M0) and video_out reader (M1).
// Grants are held for a whole CYC/LOCK transaction; a watchdog aborts stalled owners with ERR.
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   nRST,
    wb_ram_arbiter_if.slave        m0,
    wb_ram_arbiter_if.slave        m1,
    input  logic                   m1_urgent,
    wb_ram_arbiter_if.master       s,
    output logic [1:0]             grant,
    output logic                   timeout_irq
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;

    logic       own;
    logic       owner;
    logic       own_cyc, own_lock, own_stb;
    logic [1:0] pick;
    logic       wd_clr, wd_inc, wd_expired;

    logic [ADDR_W-1:0] adr_mux;
    logic [DATA_W-1:0] wdat_mux;

    assign own      = (state_q == StOwn0) || (state_q == StOwn1);
    assign owner    = (state_q == StOwn1);
    assign own_cyc  = owner ? m1.cyc  : m0.cyc;
    assign own_lock = owner ? m1.lock : m0.lock;
    assign own_stb  = owner ? m1.stb  : m0.stb;
    assign pick     = rr_pick({m1.cyc, m0.cyc}, last_q, m1_urgent);

    // ACK wins over a same-cycle expiry because a stall cycle requires ACK low.
    assign wd_inc = own && own_stb && !s.ack;
    assign wd_clr = !own || s.ack;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .nRST    (nRST),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick == 2'b01) begin
                    state_d = StOwn0;
                end else if (pick == 2'b10) begin
                    state_d = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                if (!own_cyc && !own_lock) begin
                    state_d = StIdle;
                    last_d  = owner;
                end else if (wd_expired) begin
                    // Pointer moves now so ABORT knows whose ERR to raise.
                    state_d = StAbort;
                    last_d  = owner;
                end
            end
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        grant = GRANT_NONE;
        if (state_q == StOwn0) begin
            grant[M0_IDX] = 1'b1;
        end else if (state_q == StOwn1) begin
            grant[M1_IDX] = 1'b1;
        end
    end

    // All RAM-side outputs are zero unless someone owns the bus.
    always_comb begin
        s.stb    = 1'b0;
        s.cyc    = 1'b0;
        s.lock   = 1'b0;
        s.we     = 1'b0;
        s.sel    = 4'h0;
        adr_mux  = '0;
        wdat_mux = '0;
        unique case (grant)
            2'b01: begin
                s.stb    = m0.stb;
                s.cyc    = m0.cyc;
                s.lock   = m0.lock;
                s.we     = m0.we;
                s.sel    = m0.sel;
                adr_mux  = m0.adr;
                wdat_mux = m0.wdat;
            end
            2'b10: begin
                s.stb    = m1.stb;
                s.cyc    = m1.cyc;
                s.lock   = m1.lock;
                s.we     = m1.we;
                s.sel    = m1.sel;
                adr_mux  = m1.adr;
                wdat_mux = m1.wdat;
            end
            default: ;
        endcase
    end

    assign s.adr  = adr_mux;
    assign s.wdat = wdat_mux;

    assign m0.ack  = grant[M0_IDX] && s.ack;
    assign m1.ack  = grant[M1_IDX] && s.ack;
    assign m0.rdat = s.rdat;
    assign m1.rdat = s.rdat;

    assign timeout_irq = (state_q == StAbort);
    assign m0.err      = timeout_irq && !last_q;
    assign m1.err      = timeout_irq && last_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: single requester, round-robin ties, urgent
// override, LOCK hold, watchdog abort and asynchronous reset mid-transaction.
module tb_wb_ram_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       m1_urgent = 1'b0;
    logic [1:0] grant;
    logic       timeout_irq;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    wb_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
    wb_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
    wb_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

    wb_ram_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .m1_urgent   (m1_urgent),
        .s           (s_bus),
        .grant       (grant),
        .timeout_irq (timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic cyc, input logic stb, input logic lock,
                         input logic [31:0] adr);
        if (idx == 0) begin
            m0_bus.cyc  = cyc;
            m0_bus.stb  = stb;
            m0_bus.lock = lock;
            m0_bus.adr  = adr;
        end else begin
            m1_bus.cyc  = cyc;
            m1_bus.stb  = stb;
            m1_bus.lock = lock;
            m1_bus.adr  = adr;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no end, expected finish");
        $fatal(1);
    end

    initial begin
        m0_bus.we = 1'b1;  m0_bus.sel = 4'hF; m0_bus.wdat = 32'h1111_0000;
        m1_bus.we = 1'b0;  m1_bus.sel = 4'hF; m1_bus.wdat = 32'h0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
        s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.rdat = 32'h0;

        // Reset values
        #2;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_s_cyc", 32'(s_bus.cyc), 32'h0);
        check_eq("rst_s_stb", 32'(s_bus.stb), 32'h0);
        check_eq("rst_m0_ack", 32'(m0_bus.ack), 32'h0);
        check_eq("rst_m1_err", 32'(m1_bus.err), 32'h0);
        check_eq("rst_irq", 32'(timeout_irq), 32'h0);
        step(); step();
        nRST = 1'b1;

        // Single requester M1, ACK two cycles after grant
        drive(1, 1'b1, 1'b1, 1'b0, 32'h0000_1000);
        #1;
        check_eq("t1_pre_grant", 32'(grant), 32'h0);
        step();
        check_eq("t1_grant", 32'(grant), 32'h2);
        check_eq("t1_s_adr", s_bus.adr, 32'h0000_1000);
        check_eq("t1_s_cyc", 32'(s_bus.cyc), 32'h1);
        check_eq("t1_m1_ack_wait", 32'(m1_bus.ack), 32'h0);
        step();
        s_bus.ack = 1'b1; s_bus.rdat = 32'hCAFE_0001;
        #1;
        check_eq("t1_m1_ack", 32'(m1_bus.ack), 32'h1);
        check_eq("t1_m0_ack", 32'(m0_bus.ack), 32'h0);
        check_eq("t1_m1_rdat", m1_bus.rdat, 32'hCAFE_0001);
        check_eq("t1_m0_rdat", m0_bus.rdat, 32'hCAFE_0001);
        step();
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
        s_bus.ack = 1'b0;
        #1;
        check_eq("t1_m1_ack_end", 32'(m1_bus.ack), 32'h0);
        step();
        check_eq("t1_release", 32'(grant), 32'h0);

        // Tie round-robin: M1 served last, so M0 first, then alternate
        drive(0, 1'b1, 1'b1, 1'b0, 32'h100);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h2000);
        for (int i = 0; i < 8; i++) begin
            int own;
            own = i % 2;
            #1;
            check_eq("rr_gap_cyc", 32'(s_bus.cyc), 32'h0);
            step();
            check_eq("rr_grant", 32'(grant), (own == 1) ? 32'h2 : 32'h1);
            check_eq("rr_adr", s_bus.adr, (own == 1) ? 32'h2000 : 32'h100);
            s_bus.ack = 1'b1;
            #1;
            check_eq("rr_ack", 32'((own == 1) ? m1_bus.ack : m0_bus.ack), 32'h1);
            check_eq("rr_other_ack", 32'((own == 1) ? m0_bus.ack : m1_bus.ack), 32'h0);
            step();
            drive(own, 1'b0, 1'b0, 1'b0, 32'h0);
            s_bus.ack = 1'b0;
            step();
            if (i < 7) begin
                drive(own, 1'b1, 1'b1, 1'b0, (own == 1) ? 32'h2000 : 32'h100);
            end
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // Urgent override: last = M1, tie with urgent -> M1 again
        drive(0, 1'b1, 1'b1, 1'b0, 32'h100);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h2000);
        m1_urgent = 1'b1;
        step();
        check_eq("urg_m1", 32'(grant), 32'h2);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
        m1_urgent = 1'b0;
        step();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h100);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h2000);
        step();
        check_eq("urg_off", 32'(grant), 32'h1);
        m1_urgent = 1'b1;
        step();
        check_eq("urg_no_preempt", 32'(grant), 32'h1);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
        m1_urgent = 1'b0;
        step();

        // LOCK hold across a CYC gap while M1 waits
        drive(0, 1'b1, 1'b1, 1'b1, 32'h300);
        step();
        check_eq("lock_grant", 32'(grant), 32'h1);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h2100);
        drive(0, 1'b0, 1'b0, 1'b1, 32'h300);
        step();
        check_eq("lock_hold", 32'(grant), 32'h1);
        check_eq("lock_s_cyc", 32'(s_bus.cyc), 32'h0);
        drive(0, 1'b1, 1'b1, 1'b1, 32'h304);
        step();
        check_eq("lock_resume", 32'(grant), 32'h1);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_eq("lock_gap", 32'(grant), 32'h0);
        check_eq("lock_gap_cyc", 32'(s_bus.cyc), 32'h0);
        step();
        check_eq("lock_next", 32'(grant), 32'h2);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // Watchdog: M0 never ACKed, abort on the 8th stalled cycle
        drive(0, 1'b1, 1'b1, 1'b0, 32'h400);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h2200);
        step();
        for (int k = 1; k <= 7; k++) begin
            check_eq("to_grant", 32'(grant), 32'h1);
            check_eq("to_err_early", 32'(m0_bus.err), 32'h0);
            check_eq("to_irq_early", 32'(timeout_irq), 32'h0);
            step();
        end
        check_eq("to_m0_err", 32'(m0_bus.err), 32'h1);
        check_eq("to_irq", 32'(timeout_irq), 32'h1);
        check_eq("to_s_cyc", 32'(s_bus.cyc), 32'h0);
        check_eq("to_s_stb", 32'(s_bus.stb), 32'h0);
        check_eq("to_m1_err", 32'(m1_bus.err), 32'h0);
        s_bus.ack = 1'b1;
        #1;
        check_eq("to_ack_drop", 32'(m0_bus.ack), 32'h0);
        s_bus.ack = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_eq("to_err_clear", 32'(m0_bus.err), 32'h0);
        check_eq("to_irq_clear", 32'(timeout_irq), 32'h0);
        step();
        check_eq("to_m1_grant", 32'(grant), 32'h2);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();

        // Asynchronous reset during OWN1 with ACK arriving
        drive(1, 1'b1, 1'b1, 1'b0, 32'h3000);
        step();
        check_eq("rb_grant", 32'(grant), 32'h2);
        s_bus.ack = 1'b1;
        #2;
        nRST = 1'b0;
        #1;
        check_eq("rb_grant_rst", 32'(grant), 32'h0);
        check_eq("rb_s_cyc", 32'(s_bus.cyc), 32'h0);
        check_eq("rb_s_stb", 32'(s_bus.stb), 32'h0);
        check_eq("rb_m1_ack", 32'(m1_bus.ack), 32'h0);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h500);
        s_bus.ack = 1'b0;
        step();
        nRST = 1'b1;
        step();
        check_eq("rb_first_tie", 32'(grant), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
- Shares the single Wishbone master port to frame RAM between two requesters: M0 = video_in pixel writer, M1 = video_out pixel reader.
- Round-robin arbitration, with an urgent override for the video_out reader when its output fifo is nearly empty.
- A grant is held for the whole CYC/LOCK transaction.
- A watchdog aborts stalled transactions with ERR.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width.
- TIMEOUT, 64, maximum consecutive granted cycles without ACK before abort (must be ≥2).

Ports:
- clk  in  1  system clock (100 MHz); the block has one clock; all logic is on this clock.
- nRST  in  1  reset, asynchronous, active-low.
- m0_STB_I, m0_CYC_I, m0_LOCK_I, m0_WE_I  in  1 each  M0 bus controls.
- m0_SEL_I  in  4  M0 byte select.
- m0_ADR_I  in  ADDR_W  M0 address.
- m0_DAT_I  in  DATA_W  M0 write data.
- m0_ACK_O, m0_ERR_O  out  1 each  M0 acknowledge and error.
- m0_DAT_O  out  DATA_W  M0 read data.
- m1_STB_I, m1_CYC_I, m1_LOCK_I, m1_WE_I, m1_SEL_I, m1_ADR_I, m1_DAT_I, m1_ACK_O, m1_ERR_O, m1_DAT_O  same widths and meaning as M0, for M1.
- m1_urgent  in  1  M1 fifo below low-water mark.
- s_STB_O, s_CYC_O, s_LOCK_O, s_WE_O  out  1 each  to RAM.
- s_SEL_O  out  4  to RAM.
- s_ADR_O  out  ADDR_W  to RAM.
- s_DAT_O  out  DATA_W  to RAM.
- s_ACK_I  in  1  from RAM.
- s_DAT_I  in  DATA_W  from RAM.
- grant  out  2  one-hot owner (bit0 = M0, bit1 = M1); 00 = none.
- timeout_irq  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values:
  - state IDLE, grant = 00, last-served pointer = M1 (so M0 wins the first tie).
  - watchdog = 0, timeout_irq = 0.
  - All s_* outputs 0; all m*_ACK_O and m*_ERR_O 0.
- Reset mid-transaction returns immediately to these values. No ACK is forwarded after reset asserts.
- FSM states: IDLE, OWN0, OWN1, ABORT.
- IDLE, request = mN_CYC_I:
  - Only one requester → grant it.
  - Both request, m1_urgent = 1 → OWN1.
  - Both request, m1_urgent = 0 → the requester not served last.
  - Transition is registered: grant appears 1 cycle after CYC is first sampled high.
  - Requesters must hold CYC/STB until ACK (standard Wishbone).
- OWNn, forwarding (combinational, zero latency):
  - s_* = owner's inputs.
  - Owner's ACK_O = s_ACK_I; non-owner ACK_O = 0.
  - Both m*_DAT_O = s_DAT_I (broadcast).
  - With grant = 00, s_CYC_O and s_STB_O are forced to 0.
- OWNn, release:
  - Leave when the owner's CYC_I = 0 and LOCK_I = 0 in the same cycle → IDLE, and update the last-served pointer to n.
  - CYC low with LOCK high keeps the grant (locked read-modify-write or burst).
  - One mandatory IDLE cycle between owners, so s_CYC_O is 0 for at least 1 cycle at every handover.
- Urgent: only sampled at arbitration in IDLE. It never preempts a live grant.
- Watchdog:
  - In OWNn, the counter increments each cycle with STB high and ACK low. It clears on ACK or on leaving OWNn.
  - Reaching TIMEOUT-1 → ABORT.
- ABORT (1 cycle):
  - s_CYC_O = s_STB_O = 0.
  - Owner's ERR_O = 1; timeout_irq = 1.
  - Next state IDLE; pointer updated as for a normal release.
  - An ACK arriving during ABORT is dropped.
- Simultaneous ACK and timeout in the same cycle: ACK wins and the counter clears.
- Requester dropping CYC before ACK: legal abandonment. Release as normal; a late ACK is not forwarded, since grant is already 00 next cycle.
- ERR_O is never asserted outside ABORT.

Decomposition:
- Package wb_arb_pkg:
  - state enum {IDLE, OWN0, OWN1, ABORT}.
  - localparams M0_IDX = 0, M1_IDX = 1, GRANT_NONE = 2'b00.
  - Function rr_pick(req, last, urgent) returning the one-hot grant.
- Sub-module wb_arb_watchdog: counter, clear/enable, and expiry compare, parameterised by TIMEOUT.
- Mux, FSM and ACK/ERR routing stay in the top level.

Test Plan:
- Single requester: M1 CYC/STB with ADR = 0x0000_1000, RAM ACK 2 cycles later → grant = 10 one cycle after CYC, s_ADR_O = 0x1000, m1_ACK_O pulses with s_ACK_I, m0_ACK_O stays 0.
- Tie round-robin: both request continuously, 4 single-beat transactions each → grant sequence 01, 10, 01, 10, with an IDLE cycle (s_CYC_O = 0) between each.
- Urgent override: last served = M1, both request, m1_urgent = 1 → grant = 10 (M1 again); with m1_urgent = 0 → grant = 01.
- Lock hold: M0 asserts LOCK, drops CYC for 1 cycle mid-sequence while M1 requests → grant stays 01 until LOCK and CYC are both low.
- Timeout: TIMEOUT = 8, RAM never ACKs M0 → at the 8th stalled cycle m0_ERR_O = 1 and timeout_irq = 1 for one cycle, s_CYC_O = 0, then pending M1 is granted.
- Reset mid-burst: nRST low during OWN1 with ACK pending → all outputs 0 asynchronously, grant = 00; after release, M0 wins the first tie.
